// File: rtl/serial_byte_assembler_if.sv
// rtl/serial_byte_assembler_if.sv - serial bit input and word handshake bundle for the byte assembler
`timescale 1ns/1ps

interface serial_byte_assembler_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             data_in;
  logic             write_in;
  logic             ack_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic [CNT_W-1:0] bit_count;
  logic             overflow;

  modport master (
    output data_in, write_in, ack_in,
    input  data_out, data_valid, bit_count, overflow
  );

  modport slave (
    input  data_in, write_in, ack_in,
    output data_out, data_valid, bit_count, overflow
  );
endinterface

// File: rtl/serial_byte_assembler.sv
// rtl/serial_byte_assembler.sv - collects MSB-first serial bits into words and offers them via valid/ack
`timescale 1ns/1ps

module serial_byte_assembler #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                  clock1M,
  input  logic                  reset,
  serial_byte_assembler_if.slave bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic             write_q;
  logic [WIDTH-2:0] shift_q;
  logic [CNT_W-1:0] bit_count_q;
  logic [WIDTH-1:0] data_out_q;
  logic             data_valid_q;
  logic             overflow_q;

  logic             stb;
  logic             word_done;
  logic [WIDTH-1:0] word;

  assign stb       = bus.write_in & ~write_q;
  assign word_done = stb && (bit_count_q == CNT_W'(WIDTH - 1));
  assign word      = {shift_q, bus.data_in};

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.bit_count  = bit_count_q;
  assign bus.overflow   = overflow_q;

  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      state        <= EMPTY;
      write_q      <= 1'b1;  // a strobe held high across release must not count as a bit
      shift_q      <= '0;
      bit_count_q  <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      write_q <= bus.write_in;

      if (stb) begin
        if (word_done) begin
          shift_q     <= '0;
          bit_count_q <= '0;
        end else begin
          shift_q     <= word[WIDTH-2:0];
          bit_count_q <= bit_count_q + CNT_W'(1);
        end
      end

      // Input side never stalls: a word finishing while the holder is busy and unacked is lost.
      case (state)
        EMPTY: begin
          if (word_done) begin
            data_out_q   <= word;
            data_valid_q <= 1'b1;
            state        <= FULL;
          end
        end
        FULL: begin
          if (word_done) begin
            if (bus.ack_in) begin
              data_out_q <= word;
            end else begin
              overflow_q <= 1'b1;
            end
          end else if (bus.ack_in) begin
            data_valid_q <= 1'b0;
            state        <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_byte_assembler.sv
// tb/tb_serial_byte_assembler.sv - scoreboard bench for serial_byte_assembler
`timescale 1ns/1ps

module tb_serial_byte_assembler;

  logic       clock1M = 1'b0;
  logic       reset   = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb_q[$];
  logic       lat_valid;
  logic       lat_ovf;
  logic [7:0] lat_out;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_out   = 8'h00;

  serial_byte_assembler_if sbif ();

  serial_byte_assembler dut (
    .clock1M (clock1M),
    .reset   (reset),
    .bus     (sbif)
  );

  always #500 clock1M = ~clock1M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock1M);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sbif.data_in  = b;
    sbif.write_in = 1'b1;
    tick(10);
    sbif.write_in = 1'b0;
    tick(10);
  endtask

  // Last bit optionally carries a one-cycle ack aligned with its strobe; outputs
  // are captured one clock after that bit's write_in rise.
  task automatic send_byte(input logic [7:0] value, input logic ack_last,
                           input logic push, input logic chk_cnt);
    if (push) sb_q.push_back(value);
    for (int i = 0; i < 8; i++) begin
      sbif.data_in  = value[7-i];
      sbif.write_in = 1'b1;
      if (i == 7) begin
        if (ack_last) sbif.ack_in = 1'b1;
        tick(1);
        if (ack_last) sbif.ack_in = 1'b0;
        lat_valid = sbif.data_valid;
        lat_out   = sbif.data_out;
        lat_ovf   = sbif.overflow;
        tick(9);
      end else begin
        tick(10);
      end
      sbif.write_in = 1'b0;
      tick(10);
      if (chk_cnt) chk($sformatf("bit_count_%0d", i), sbif.bit_count, (i + 1) % 8);
    end
  endtask

  task automatic pulse_ack();
    sbif.ack_in = 1'b1;
    tick(1);
    sbif.ack_in = 1'b0;
  endtask

  // Every newly presented word must be the oldest outstanding expectation.
  always @(negedge clock1M) begin
    if (sbif.data_valid === 1'b1 && (!prev_valid || sbif.data_out !== prev_out)) begin
      if (sb_q.size() == 0) chk("sb_unexpected_word", sb_q.size(), 1);
      else                  chk("sb_word", sbif.data_out, sb_q.pop_front());
    end
    prev_valid = sbif.data_valid;
    prev_out   = sbif.data_out;
  end

  initial begin
    repeat (20000) @(posedge clock1M);
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    sbif.data_in  = 1'b0;
    sbif.write_in = 1'b0;
    sbif.ack_in   = 1'b0;
    reset         = 1'b0;
    tick(10);
    chk("rst_data_out", sbif.data_out, 8'h00);
    chk("rst_data_valid", sbif.data_valid, 1'b0);
    chk("rst_bit_count", sbif.bit_count, 0);
    chk("rst_overflow", sbif.overflow, 1'b0);
    reset = 1'b1;
    tick(2);

    send_byte(8'hA5, 1'b0, 1'b1, 1'b1);
    chk("a5_valid_lat", lat_valid, 1'b1);
    chk("a5_out_lat", lat_out, 8'hA5);
    chk("a5_ovf", lat_ovf, 1'b0);

    send_byte(8'h3C, 1'b0, 1'b0, 1'b1);
    chk("drop_ovf_lat", lat_ovf, 1'b1);
    chk("drop_out_kept", lat_out, 8'hA5);
    chk("drop_valid_kept", lat_valid, 1'b1);
    pulse_ack();
    chk("ack_clears_valid", sbif.data_valid, 1'b0);
    chk("ack_keeps_out", sbif.data_out, 8'hA5);
    chk("ovf_sticky", sbif.overflow, 1'b1);

    reset = 1'b0;
    tick(3);
    chk("rst2_overflow", sbif.overflow, 1'b0);
    reset = 1'b1;
    tick(2);
    send_byte(8'hA5, 1'b0, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b1, 1'b0);
    chk("same_cycle_out", lat_out, 8'h3C);
    chk("same_cycle_valid", lat_valid, 1'b1);
    chk("same_cycle_ovf", lat_ovf, 1'b0);

    pulse_ack();
    tick(1);
    chk("empty_after_ack", sbif.data_valid, 1'b0);
    sbif.data_in  = 1'b1;
    sbif.write_in = 1'b1;
    tick(500);
    sbif.write_in = 1'b0;
    tick(2);
    chk("long_hold_count", sbif.bit_count, 1);
    pulse_ack();
    tick(1);
    chk("idle_ack_count", sbif.bit_count, 1);
    chk("idle_ack_valid", sbif.data_valid, 1'b0);
    chk("idle_ack_out", sbif.data_out, 8'h3C);
    chk("idle_ack_ovf", sbif.overflow, 1'b0);

    for (int i = 0; i < 4; i++) send_bit(i[0]);
    chk("mid_word_count", sbif.bit_count, 5);
    sbif.write_in = 1'b1;
    reset         = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(3);
    chk("rel_bit_count", sbif.bit_count, 0);
    chk("rel_data_out", sbif.data_out, 8'h00);
    chk("rel_data_valid", sbif.data_valid, 1'b0);
    chk("rel_overflow", sbif.overflow, 1'b0);
    sbif.write_in = 1'b0;
    tick(10);
    send_byte(8'hFF, 1'b0, 1'b1, 1'b0);
    chk("ff_out", lat_out, 8'hFF);
    chk("ff_valid", lat_valid, 1'b1);
    pulse_ack();
    tick(2);

    fork
      begin
        send_byte(8'h01, 1'b0, 1'b1, 1'b0);
        send_byte(8'h80, 1'b0, 1'b1, 1'b0);
      end
      begin
        for (int w = 0; w < 2; w++) begin
          int t;
          t = 0;
          while (sbif.data_valid !== 1'b1 && t < 400) begin
            tick(1);
            t++;
          end
          chk($sformatf("b2b_wait_%0d", w), (t < 400), 1'b1);
          tick(50);
          chk($sformatf("b2b_ovf_%0d", w), sbif.overflow, 1'b0);
          pulse_ack();
        end
      end
    join
    tick(5);
    chk("b2b_final_out", sbif.data_out, 8'h80);
    chk("b2b_final_valid", sbif.data_valid, 1'b0);
    chk("b2b_final_ovf", sbif.overflow, 1'b0);
    chk("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
